// File: rtl/lsu_axi_lite_master_if.sv
// lsu_axi_lite_master_if: LSU request/response channel plus AXI4-Lite master channels.
//   master modport: the bus master (accepts LSU requests, drives AW/W/AR, consumes B/R)
//   slave modport:  the LSU and memory side seen from outside the master
interface lsu_axi_lite_master_if #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
);
   logic                req_valid, req_ready, req_wen, req_unsigned;
   logic [ADDR_LEN-1:0] req_addr;
   logic [DATA_LEN-1:0] req_wdata;
   logic [1:0]          req_size;
   logic                rsp_valid, rsp_ready, rsp_err, rsp_misalign;
   logic [DATA_LEN-1:0] rsp_rdata;
   logic [ADDR_LEN-1:0] awaddr, araddr;
   logic                awvalid, awready, wvalid, wready, bvalid, bready;
   logic                arvalid, arready, rvalid, rready;
   logic [DATA_LEN-1:0] wdata, rdata;
   logic [3:0]          wstrb;
   logic [1:0]          bresp, rresp;
   modport master (
      input  req_valid, req_wen, req_unsigned, req_addr, req_wdata, req_size, rsp_ready,
             awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      output req_ready, rsp_valid, rsp_err, rsp_misalign, rsp_rdata,
             awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
   );
   modport slave (
      output req_valid, req_wen, req_unsigned, req_addr, req_wdata, req_size, rsp_ready,
             awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
      input  req_ready, rsp_valid, rsp_err, rsp_misalign, rsp_rdata,
             awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
   );
endinterface

// File: rtl/lsu_axi_lite_master.sv
// lsu_axi_lite_master: runs one LSU load/store as a single AXI4-Lite transaction.
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus_io - LSU req/rsp handshake and AXI4-Lite AW/W/B/AR/R channels (master modport)
module lsu_axi_lite_master #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   lsu_axi_lite_master_if.master        bus_io
);
   typedef enum logic [2:0] {IDLE, RD, RDATA, WR, WRESP, RESP} state_e;
   state_e              state_q, state_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic [DATA_LEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sh, ld;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                err_q, err_d, mis_q, mis_d, misalign;
   assign misalign = (bus_io.req_size == 2'd1 & bus_io.req_addr[0]) |
                     (bus_io.req_size[1] & |bus_io.req_addr[1:0]);
   assign sh = bus_io.rdata >> {addr_q[1:0], 3'b000};
   assign ld = size_q == 2'd0 ? {{(DATA_LEN-8){~uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'd1 ? {{(DATA_LEN-16){~uns_q & sh[15]}}, sh[15:0]} : sh;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wstrb_q   <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         wstrb_q   <= wstrb_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
         mis_q     <= mis_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      wstrb_d   = wstrb_q;
      size_d    = size_q;
      uns_d     = uns_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      mis_d     = mis_q;
      case (state_q)
         IDLE: if (bus_io.req_valid) begin
            addr_d    = bus_io.req_addr;
            size_d    = bus_io.req_size;
            uns_d     = bus_io.req_unsigned;
            wdata_d   = bus_io.req_wdata << {bus_io.req_addr[1:0], 3'b000};
            wstrb_d   = (bus_io.req_size == 2'd0 ? 4'b0001 :
                         bus_io.req_size == 2'd1 ? 4'b0011 : 4'b1111) << bus_io.req_addr[1:0];
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            rdata_d   = '0;
            err_d     = misalign;
            mis_d     = misalign;
            state_d   = misalign ? RESP : bus_io.req_wen ? WR : RD;
         end
         RD: if (bus_io.arready) state_d = RDATA;
         RDATA: if (bus_io.rvalid) begin
            rdata_d = |bus_io.rresp ? '0 : ld;
            err_d   = |bus_io.rresp;
            state_d = RESP;
         end
         // AW and W complete independently; a ready seen after its own handshake is harmless
         WR: begin
            aw_done_d = aw_done_q | bus_io.awready;
            w_done_d  = w_done_q | bus_io.wready;
            state_d   = aw_done_d & w_done_d ? WRESP : WR;
         end
         WRESP: if (bus_io.bvalid) begin
            err_d   = |bus_io.bresp;
            state_d = RESP;
         end
         RESP: if (bus_io.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // every output is a decode of registered state, so no AXI input reaches an AXI output
   assign bus_io.req_ready    = state_q == IDLE;
   assign bus_io.arvalid      = state_q == RD;
   assign bus_io.rready       = state_q == RDATA;
   assign bus_io.awvalid      = state_q == WR & ~aw_done_q;
   assign bus_io.wvalid       = state_q == WR & ~w_done_q;
   assign bus_io.bready       = state_q == WRESP;
   assign bus_io.rsp_valid    = state_q == RESP;
   assign bus_io.rsp_rdata    = rdata_q;
   assign bus_io.rsp_err      = err_q;
   assign bus_io.rsp_misalign = mis_q;
   assign bus_io.awaddr       = addr_q;
   assign bus_io.araddr       = addr_q;
   assign bus_io.wdata        = wdata_q;
   assign bus_io.wstrb        = wstrb_q;
endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// tb_lsu_axi_lite_master: table-driven check of the LSU AXI4-Lite master with a cycle-stepped slave.
module tb_lsu_axi_lite_master;
   logic clk_i, rst_ni;
   int total = 0, bad = 0;
   lsu_axi_lite_master_if b ();
   lsu_axi_lite_master dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus_io(b));
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   typedef struct {
      logic        wen;
      logic [31:0] addr, wd;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] srd;
      logic [1:0]  sresp;
      int          aw_w, w_w, rsp_w;
      logic [31:0] e_rd;
      logic        e_err, e_mis;
      logic [3:0]  e_strb;
      logic [31:0] e_wd;
      int          e_lat;
   } vec_t;
   vec_t vecs[14];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask
   task automatic slave_idle();
      b.arready = 0; b.rvalid = 0; b.rdata = 0; b.rresp = 0;
      b.awready = 0; b.wready = 0; b.bvalid = 0; b.bresp = 0;
      b.rsp_ready = 0;
   endtask
   task automatic run(input string nm, input vec_t v);
      int lat = -1, ar_n = 0, aw_n = 0, w_n = 0, rsp_n = 0;
      bit r_pend = 0, b_pend = 0, b_given = 0, aw_hs = 0, w_hs = 0, done = 0;
      bit addr_ok = 1, wd_ok = 1, stable = 1, busy_ok = 1;
      logic [31:0] h_rd;
      logic h_err, h_mis;
      @(negedge clk_i);
      chk({nm, "_req_ready_idle"}, b.req_ready, 1);
      b.req_valid = 1; b.req_wen = v.wen; b.req_addr = v.addr; b.req_wdata = v.wd;
      b.req_size = v.size; b.req_unsigned = v.uns;
      @(posedge clk_i);
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk_i);
         b.req_valid = 0; b.req_wen = ~v.wen; b.req_addr = ~v.addr; b.req_wdata = ~v.wd;
         b.req_size = ~v.size; b.req_unsigned = ~v.uns;
         if (b.req_ready) busy_ok = 0;
         if (b.arvalid) begin ar_n++; if (b.araddr !== v.addr) addr_ok = 0; end
         if (b.awvalid) begin aw_n++; if (b.awaddr !== v.addr) addr_ok = 0; end
         if (b.wvalid) begin w_n++; if (b.wdata !== v.e_wd || b.wstrb !== v.e_strb) wd_ok = 0; end
         b.arready = b.arvalid;
         b.rvalid  = r_pend; b.rdata = r_pend ? v.srd : 32'h0; b.rresp = v.sresp;
         b.awready = b.awvalid && aw_n > v.aw_w;
         b.wready  = b.wvalid && w_n > v.w_w;
         b.bvalid  = b_pend; b.bresp = v.sresp;
         if (b.rsp_valid) begin
            rsp_n++;
            if (lat < 0) begin
               lat = c; h_rd = b.rsp_rdata; h_err = b.rsp_err; h_mis = b.rsp_misalign;
            end else if (b.rsp_rdata !== h_rd || b.rsp_err !== h_err || b.rsp_misalign !== h_mis)
               stable = 0;
         end
         b.rsp_ready = b.rsp_valid && rsp_n > v.rsp_w;
         if (b.arvalid && b.arready) r_pend = 1;
         if (b.rvalid && b.rready) r_pend = 0;
         if (b.awvalid && b.awready) aw_hs = 1;
         if (b.wvalid && b.wready) w_hs = 1;
         if (b.bvalid && b.bready) b_pend = 0;
         else if (aw_hs && w_hs && !b_given) begin b_pend = 1; b_given = 1; end
         if (b.rsp_valid && b.rsp_ready) done = 1;
         @(posedge clk_i);
      end
      @(negedge clk_i);
      slave_idle();
      chk({nm, "_done"}, done, 1);
      chk({nm, "_lat"}, lat, v.e_lat);
      chk({nm, "_rdata"}, h_rd, v.e_rd);
      chk({nm, "_err"}, h_err, v.e_err);
      chk({nm, "_mis"}, h_mis, v.e_mis);
      chk({nm, "_ar_cycles"}, ar_n, (!v.wen && !v.e_mis) ? 1 : 0);
      chk({nm, "_aw_cycles"}, aw_n, (v.wen && !v.e_mis) ? v.aw_w + 1 : 0);
      chk({nm, "_w_cycles"}, w_n, (v.wen && !v.e_mis) ? v.w_w + 1 : 0);
      chk({nm, "_addr"}, addr_ok, 1);
      chk({nm, "_wdata_strb"}, wd_ok, 1);
      chk({nm, "_rsp_stable"}, stable, 1);
      chk({nm, "_rsp_cycles"}, rsp_n, v.rsp_w + 1);
      chk({nm, "_busy_not_ready"}, busy_ok, 1);
      chk({nm, "_ready_after"}, b.req_ready, 1);
      chk({nm, "_rsp_dropped"}, b.rsp_valid, 0);
   endtask
   initial begin
      vec_t lw;
      //           wen addr          wd            sz uns srd           rsp aw w rsp e_rd          err mis strb    e_wd          lat
      vecs[0]  = '{0, 32'h8000_0010, 32'h0,        2, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0,        3};
      vecs[1]  = '{0, 32'h8000_0013, 32'h0,        0, 0, 32'h80FF_0000, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 0, 4'h0, 32'h0,        3};
      vecs[2]  = '{0, 32'h8000_0013, 32'h0,        0, 1, 32'h80FF_0000, 0, 0, 0, 0, 32'h0000_0080, 0, 0, 4'h0, 32'h0,        3};
      vecs[3]  = '{1, 32'h8000_0002, 32'h1234,     1, 0, 32'h0,         0, 0, 3, 0, 32'h0,         0, 0, 4'hC, 32'h1234_0000, 6};
      vecs[4]  = '{0, 32'h8000_0006, 32'h0,        2, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 1, 4'h0, 32'h0,        1};
      vecs[5]  = '{1, 32'h8000_0001, 32'hAB,       0, 0, 32'h0,         2, 0, 0, 4, 32'h0,         1, 0, 4'h2, 32'h0000_AB00, 3};
      vecs[6]  = '{0, 32'h8000_0002, 32'h0,        1, 0, 32'h8001_7FFF, 0, 0, 0, 0, 32'hFFFF_8001, 0, 0, 4'h0, 32'h0,        3};
      vecs[7]  = '{0, 32'h8000_0000, 32'h0,        1, 1, 32'h1234_ABCD, 0, 0, 0, 0, 32'h0000_ABCD, 0, 0, 4'h0, 32'h0,        3};
      vecs[8]  = '{0, 32'h8000_000C, 32'h0,        2, 0, 32'h1234_5678, 3, 0, 0, 0, 32'h0,         1, 0, 4'h0, 32'h0,        3};
      vecs[9]  = '{1, 32'h8000_0008, 32'hCAFE_F00D, 2, 0, 32'h0,        0, 3, 0, 0, 32'h0,         0, 0, 4'hF, 32'hCAFE_F00D, 6};
      vecs[10] = '{1, 32'h8000_0003, 32'h1234,     1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 1, 4'h0, 32'h0,        1};
      vecs[11] = '{0, 32'h8000_0004, 32'h0,        3, 0, 32'h1122_3344, 0, 0, 0, 0, 32'h1122_3344, 0, 0, 4'h0, 32'h0,        3};
      vecs[12] = '{1, 32'h8000_0003, 32'h5A,       0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0, 4'h8, 32'h5A00_0000, 3};
      vecs[13] = '{0, 32'h8000_0001, 32'h0,        1, 1, 32'h0,         0, 0, 0, 0, 32'h0,         1, 1, 4'h0, 32'h0,        1};
      lw       = '{0, 32'h8000_0024, 32'h0,        2, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0, 4'h0, 32'h0,        3};
      rst_ni = 0;
      b.req_valid = 0; b.req_wen = 0; b.req_addr = 0; b.req_wdata = 0; b.req_size = 0; b.req_unsigned = 0;
      slave_idle();
      #12;
      chk("rst_req_ready", b.req_ready, 1);
      chk("rst_valids", {b.arvalid, b.awvalid, b.wvalid, b.rready, b.bready, b.rsp_valid}, 0);
      chk("rst_rsp", {b.rsp_err, b.rsp_misalign}, 0);
      chk("rst_rsp_rdata", b.rsp_rdata, 0);
      chk("rst_addr", b.araddr | b.awaddr, 0);
      chk("rst_wdata", b.wdata, 0);
      chk("rst_wstrb", b.wstrb, 0);
      @(negedge clk_i);
      rst_ni = 1;
      for (int i = 0; i < 14; i++) run($sformatf("v%0d", i), vecs[i]);
      @(negedge clk_i);
      b.req_valid = 1; b.req_wen = 0; b.req_addr = 32'h8000_0020; b.req_size = 2;
      @(posedge clk_i);
      @(negedge clk_i);
      b.req_valid = 0;
      chk("rstmid_arvalid", b.arvalid, 1);
      b.arready = 1;
      @(posedge clk_i);
      @(negedge clk_i);
      b.arready = 0;
      chk("rstmid_rready", b.rready, 1);
      #2 rst_ni = 0;
      #1;
      chk("rstmid_valids", {b.arvalid, b.awvalid, b.wvalid, b.rready, b.bready, b.rsp_valid}, 0);
      chk("rstmid_req_ready", b.req_ready, 1);
      chk("rstmid_araddr", b.araddr, 0);
      @(negedge clk_i);
      rst_ni = 1;
      run("after_rst", lw);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
